// File: rtl/mouse_pos_ctrl_if.sv
// VGA timing bus seen by the cursor controller.
// Only the vertical blanking flag is carried; the source drives it through
// the 'out' modport and consumers read it through the 'in' modport.
interface vga_if;
    logic vblnk;

    modport out (output vblnk);
    modport in  (input  vblnk);
endinterface

// File: rtl/mouse_pos_ctrl.sv
// mouse_pos_ctrl: frame-synchronous cursor position controller.
// Accepts clamped position samples from the mouse decoder over a valid/ready
// handshake, holds the latest one as pending, and commits it to xpos/ypos
// only at the start of vertical blanking so the cursor never tears.
// Optional feature macro: MOUSE_POS_CTRL_AUTOHIDE_EN hides the cursor after
// HIDE_FRAMES consecutive frames without a commit.
module mouse_pos_ctrl #(
    parameter logic [11:0] XMAX        = 12'd799,
    parameter logic [11:0] YMAX        = 12'd599,
    parameter int          HIDE_FRAMES = 180
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_valid,
    output logic        mouse_ready,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        pos_update,
    output logic        cursor_en
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // A hide threshold of zero would hide the cursor with no idle frames at all.
    if (HIDE_FRAMES < 1) begin : g_hide_frames_check
        $error("HIDE_FRAMES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        vblnk_dly_q;          // vblnk registered once, for edge detection
    logic [11:0] pend_x_q, pend_x_d;
    logic [11:0] pend_y_q, pend_y_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        pos_update_q, pos_update_d;

    logic        frame_start;
    logic        accept;
    logic [11:0] clamp_x;
    logic [11:0] clamp_y;

    // Rising edge of vblnk marks the start of vertical blanking.
    assign frame_start = vga_in.vblnk & ~vblnk_dly_q;

    // Ready depends only on state, so the decoder never sees a combinational path.
    assign mouse_ready = (state_q != COMMIT);
    assign accept      = mouse_valid & mouse_ready;

    assign clamp_x = (mouse_xpos > XMAX) ? XMAX : mouse_xpos;
    assign clamp_y = (mouse_ypos > YMAX) ? YMAX : mouse_ypos;

    // Next-state and datapath decode for the capture/commit sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        pos_update_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_x_d = clamp_x;
                    pend_y_d = clamp_y;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                // Latest sample wins, including one arriving with frame_start.
                if (accept) begin
                    pend_x_d = clamp_x;
                    pend_y_d = clamp_y;
                end
                if (frame_start) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                xpos_d       = pend_x_q;
                ypos_d       = pend_y_q;
                pos_update_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending sample and committed position registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= IDLE;
            vblnk_dly_q  <= 1'b0;
            pend_x_q     <= 12'd0;
            pend_y_q     <= 12'd0;
            xpos_q       <= 12'd0;
            ypos_q       <= 12'd0;
            pos_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vblnk_dly_q  <= vga_in.vblnk;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            pos_update_q <= pos_update_d;
        end
    end

    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign pos_update = pos_update_q;

`ifdef MOUSE_POS_CTRL_AUTOHIDE_EN
    localparam int               CNT_W    = $clog2(HIDE_FRAMES + 1);
    localparam logic [CNT_W-1:0] HIDE_CNT = CNT_W'(HIDE_FRAMES);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             cursor_en_q, cursor_en_d;

    // Count commit-free frames; hide the cursor once the threshold is reached.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        cursor_en_d = cursor_en_q;
        if (state_q == COMMIT) begin
            // Re-show together with the new position.
            idle_cnt_d  = '0;
            cursor_en_d = 1'b1;
        end else begin
            // A frame_start in PENDING always leads to a commit, so it is not idle.
            if (frame_start && (state_q != PENDING) && (idle_cnt_q != HIDE_CNT)) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (idle_cnt_q == HIDE_CNT) begin
                cursor_en_d = 1'b0;
            end
        end
    end

    // Idle-frame counter and cursor enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q  <= '0;
            cursor_en_q <= 1'b1;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            cursor_en_q <= cursor_en_d;
        end
    end

    assign cursor_en = cursor_en_q;
`else
    assign cursor_en = 1'b1;
`endif

endmodule
